// File: rtl/ir_nec_pkg.sv
// NEC IR timing constants, transmitter FSM encoding and payload assembly.
// Shared by the NEC transmitter and receiver.
package ir_nec_pkg;

  localparam int unsigned NEC_AGC_CYCLES        = 900_000;
  localparam int unsigned NEC_SPACE_CYCLES      = 450_000;
  localparam int unsigned NEC_RPT_SPACE_CYCLES  = 225_000;
  localparam int unsigned NEC_MARK_CYCLES       = 56_000;
  localparam int unsigned NEC_ZERO_SPACE_CYCLES = 56_000;
  localparam int unsigned NEC_ONE_SPACE_CYCLES  = 169_000;
  localparam int unsigned NEC_GAP_CYCLES        = 4_000_000;
  localparam int unsigned NEC_CARR_PERIOD       = 2_632;
  localparam int unsigned NEC_CARR_HIGH         = 877;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AGC       = 3'd1,
    ST_SPACE     = 3'd2,
    ST_BIT_MARK  = 3'd3,
    ST_BIT_SPACE = 3'd4,
    ST_STOP      = 3'd5,
    ST_GAP       = 3'd6
  } nec_state_e;

  // Transmitted LSB first: addr, ~addr, cmd, ~cmd.
  function automatic logic [31:0] nec_payload(input logic [7:0] addr,
                                              input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: free-running phase while enabled, restarted by clr,
// output high for the first CARR_HIGH cycles of each CARR_PERIOD.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int unsigned CARR_PERIOD = NEC_CARR_PERIOD,
  parameter int unsigned CARR_HIGH   = NEC_CARR_HIGH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic carrier
);

  localparam int unsigned PW = (CARR_PERIOD > 1) ? $clog2(CARR_PERIOD) : 1;

  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == PW'(CARR_PERIOD - 1)) ? '0 : phase + PW'(1);
    end
  end

  assign carrier = en && (phase < PW'(CARR_HIGH));

endmodule

// File: rtl/ir_nec_xmt.sv
// NEC IR transmitter: sends a full NEC frame or a repeat code as an
// active-low envelope plus a carrier-modulated LED drive.
module ir_nec_xmt
  import ir_nec_pkg::*;
#(
  parameter int unsigned AGC_CYCLES        = NEC_AGC_CYCLES,
  parameter int unsigned SPACE_CYCLES      = NEC_SPACE_CYCLES,
  parameter int unsigned RPT_SPACE_CYCLES  = NEC_RPT_SPACE_CYCLES,
  parameter int unsigned MARK_CYCLES       = NEC_MARK_CYCLES,
  parameter int unsigned ZERO_SPACE_CYCLES = NEC_ZERO_SPACE_CYCLES,
  parameter int unsigned ONE_SPACE_CYCLES  = NEC_ONE_SPACE_CYCLES,
  parameter int unsigned GAP_CYCLES        = NEC_GAP_CYCLES,
  parameter int unsigned CARR_PERIOD       = NEC_CARR_PERIOD,
  parameter int unsigned CARR_HIGH         = NEC_CARR_HIGH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       repeat_code,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       ir_env,
  output logic       ir_led,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  nec_state_e  state, state_nxt;
  logic [31:0] tim;
  logic [31:0] seg_len;
  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic        is_rpt;
  logic        seg_end;
  logic        accept;
  logic        mark_q, mark_nxt;
  logic        busy_nxt, done_nxt;
  logic        carr_clr;

  assign accept    = (state == ST_IDLE) && (start || repeat_code);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Length of the segment the FSM is currently in.
  always_comb begin
    seg_len = 32'd1;
    case (state)
      ST_AGC:       seg_len = 32'(AGC_CYCLES);
      ST_SPACE:     seg_len = is_rpt ? 32'(RPT_SPACE_CYCLES) : 32'(SPACE_CYCLES);
      ST_BIT_MARK:  seg_len = 32'(MARK_CYCLES);
      ST_BIT_SPACE: seg_len = shreg[0] ? 32'(ONE_SPACE_CYCLES) : 32'(ZERO_SPACE_CYCLES);
      ST_STOP:      seg_len = 32'(MARK_CYCLES);
      ST_GAP:       seg_len = 32'(GAP_CYCLES);
      default:      seg_len = 32'd1;
    endcase
  end

  assign seg_end = (tim == seg_len - 32'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept)  state_nxt = ST_AGC;
      ST_AGC:       if (seg_end) state_nxt = ST_SPACE;
      ST_SPACE:     if (seg_end) state_nxt = is_rpt ? ST_STOP : ST_BIT_MARK;
      ST_BIT_MARK:  if (seg_end) state_nxt = ST_BIT_SPACE;
      ST_BIT_SPACE: if (seg_end) state_nxt = (bit_cnt == 5'd31) ? ST_STOP : ST_BIT_MARK;
      ST_STOP:      if (seg_end) state_nxt = ST_GAP;
      ST_GAP:       if (seg_end) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so the pins
  // change exactly once per state change and never glitch.
  always_comb begin
    mark_nxt = (state_nxt == ST_AGC) || (state_nxt == ST_BIT_MARK) ||
               (state_nxt == ST_STOP);
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_STOP) && (state_nxt == ST_GAP);
    carr_clr = mark_nxt && !mark_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mark_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      mark_q <= mark_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  assign ir_env = ~mark_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      is_rpt  <= 1'b0;
    end else begin
      tim <= ((state_nxt != state) || (state == ST_IDLE)) ? '0 : tim + 32'd1;
      if (accept) begin
        is_rpt  <= !start;
        bit_cnt <= '0;
        if (start) shreg <= nec_payload(addr, cmd);
      end else if ((state == ST_BIT_SPACE) && seg_end) begin
        bit_cnt <= bit_cnt + 5'd1;
        shreg   <= {1'b0, shreg[31:1]};
      end
    end
  end

  ir_carrier_gen #(
    .CARR_PERIOD(CARR_PERIOD),
    .CARR_HIGH  (CARR_HIGH)
  ) u_carrier (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mark_q),
    .clr    (carr_clr),
    .carrier(ir_led)
  );

endmodule
